// File: rtl/pacman_pkg.sv
// pacman_pkg: shared tile codes, default map size and tile address helper. Rev 1.0.
`default_nettype none

package pacman_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WALL   = 2'd1,
    DOT    = 2'd2,
    PACMAN = 2'd3
  } tile_t;

  localparam int MAP_W_DEF = 40;
  localparam int MAP_H_DEF = 30;

  // Row stride is fixed at 40 tiles: y*40 = (y<<5) + (y<<3), maximum address 1199.
  function automatic logic [10:0] tile_addr(input logic [5:0] x, input logic [4:0] y);
    tile_addr = ({6'd0, y} << 5) + ({6'd0, y} << 3) + {5'd0, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pacman_map_writer_if.sv
// pacman_map_writer_if: move handshake plus tile-map RAM port. Rev 1.0.
`default_nettype none

interface pacman_map_writer_if #(
  parameter int SCORE_W = 16
);
  logic               req;
  logic [5:0]         curr_x;
  logic [5:0]         next_x;
  logic [4:0]         curr_y;
  logic [4:0]         next_y;
  logic               done;
  logic               blocked;
  logic               dot_eaten;
  logic [SCORE_W-1:0] score;
  logic [10:0]        ram_addr;
  logic               ram_wren;
  logic [1:0]         ram_wdata;
  logic [1:0]         ram_rdata;

  modport master (
    output req, curr_x, next_x, curr_y, next_y, ram_rdata,
    input  done, blocked, dot_eaten, score, ram_addr, ram_wren, ram_wdata
  );

  modport slave (
    input  req, curr_x, next_x, curr_y, next_y, ram_rdata,
    output done, blocked, dot_eaten, score, ram_addr, ram_wren, ram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/tile_addr_calc.sv
// tile_addr_calc: combinational tile coordinate to RAM address, with on-map check. Rev 1.0.
`default_nettype none

module tile_addr_calc
  import pacman_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
) (
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic [10:0] addr,
  output logic        in_range
);

  assign addr     = tile_addr(x, y);
  assign in_range = ({26'd0, x} < 32'(MAP_W)) && ({27'd0, y} < 32'(MAP_H));

endmodule

`default_nettype wire

// File: rtl/pacman_map_writer.sv
// pacman_map_writer: validates a pacman move against the tile map and redraws him. Rev 1.0.
// Optional: define PACMAN_SCORE_EN to keep the saturating dot-score counter.
`default_nettype none

module pacman_map_writer
  import pacman_pkg::*;
#(
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF,
  parameter int SCORE_W = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  pacman_map_writer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    EVAL   = 3'd2,
    ERASE  = 3'd3,
    PLACE  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      state;
  logic [5:0]  cur_x_lat, nxt_x_lat;
  logic [4:0]  cur_y_lat, nxt_y_lat;
  logic        dot_flag;
  logic        done_q, blocked_q, dot_eaten_q, wren_q;
  logic [10:0] addr_q;
  tile_t       wdata_q;

  logic [5:0]  cur_x_sel, nxt_x_sel;
  logic [4:0]  cur_y_sel, nxt_y_sel;
  logic [10:0] curr_addr, next_addr;
  logic        curr_ok, next_ok, same_tile;

  // Live coordinates are only looked at in the IDLE cycle that accepts the request.
  assign cur_x_sel = (state == IDLE) ? bus.curr_x : cur_x_lat;
  assign cur_y_sel = (state == IDLE) ? bus.curr_y : cur_y_lat;
  assign nxt_x_sel = (state == IDLE) ? bus.next_x : nxt_x_lat;
  assign nxt_y_sel = (state == IDLE) ? bus.next_y : nxt_y_lat;
  assign same_tile = (cur_x_sel == nxt_x_sel) && (cur_y_sel == nxt_y_sel);

  tile_addr_calc #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_curr_addr (
    .x        (cur_x_sel),
    .y        (cur_y_sel),
    .addr     (curr_addr),
    .in_range (curr_ok)
  );

  tile_addr_calc #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_next_addr (
    .x        (nxt_x_sel),
    .y        (nxt_y_sel),
    .addr     (next_addr),
    .in_range (next_ok)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_x_lat   <= '0;
      cur_y_lat   <= '0;
      nxt_x_lat   <= '0;
      nxt_y_lat   <= '0;
      dot_flag    <= 1'b0;
      done_q      <= 1'b0;
      blocked_q   <= 1'b0;
      dot_eaten_q <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= EMPTY;
    end else begin
      done_q      <= 1'b0;
      dot_eaten_q <= 1'b0;
      wren_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            cur_x_lat <= bus.curr_x;
            cur_y_lat <= bus.curr_y;
            nxt_x_lat <= bus.next_x;
            nxt_y_lat <= bus.next_y;
            // An off-map current tile is refused too, so a bad erase can never hit the map.
            if (!next_ok || !curr_ok) begin
              blocked_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= FINISH;
            end else if (same_tile) begin
              blocked_q <= 1'b0;
              done_q    <= 1'b1;
              state     <= FINISH;
            end else begin
              addr_q <= next_addr;
              state  <= LOOKUP;
            end
          end
        end
        LOOKUP: state <= EVAL;
        EVAL: begin
          if (tile_t'(bus.ram_rdata) == WALL) begin
            blocked_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= FINISH;
          end else begin
            dot_flag <= (tile_t'(bus.ram_rdata) == DOT);
            wren_q   <= 1'b1;
            addr_q   <= curr_addr;
            wdata_q  <= EMPTY;
            state    <= ERASE;
          end
        end
        ERASE: begin
          wren_q      <= 1'b1;
          addr_q      <= next_addr;
          wdata_q     <= PACMAN;
          dot_eaten_q <= dot_flag;
          state       <= PLACE;
        end
        PLACE: begin
          blocked_q <= 1'b0;
          done_q    <= 1'b1;
          state     <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PACMAN_SCORE_EN
  logic [SCORE_W-1:0] score_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      score_q <= '0;
    end else if (state == PLACE && dot_flag && score_q != {SCORE_W{1'b1}}) begin
      score_q <= score_q + SCORE_W'(1);
    end
  end

  assign bus.score = score_q;
`else
  assign bus.score = {SCORE_W{1'b0}};
`endif

  assign bus.done      = done_q;
  assign bus.blocked   = blocked_q;
  assign bus.dot_eaten = dot_eaten_q;
  assign bus.ram_wren  = wren_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pacman_map_writer.sv
// tb_pacman_map_writer: scoreboard bench for the move handshake against a synchronous RAM model.
`default_nettype none
`timescale 1ns/1ps

module tb_pacman_map_writer;
  import pacman_pkg::*;

  localparam int SW = 2;

  typedef struct packed {
    logic [10:0] addr;
    logic [1:0]  data;
    logic [7:0]  cyc;
  } wr_t;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   exp_score = 0;

  wr_t  exp_wr[$];
  wr_t  obs_wr[$];
  int   obs_dot[$];

  logic        pk_en   = 1'b0;
  logic [10:0] pk_addr = '0;
  logic [1:0]  pk_data = '0;
  logic [1:0]  mem [0:2047];

  pacman_map_writer_if #(.SCORE_W(SW)) bus ();

  pacman_map_writer #(.MAP_W(40), .MAP_H(30), .SCORE_W(SW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic int ea(input int x, input int y);
    return y * 40 + x;
  endfunction

  function automatic int next_score(input int s);
`ifdef PACMAN_SCORE_EN
    return (s >= 3) ? 3 : s + 1;
`else
    return s * 0;
`endif
  endfunction

  task automatic poke(input int a, input tile_t t);
    @(negedge CLOCK_50);
    pk_en = 1'b1; pk_addr = 11'(a); pk_data = t;
    @(negedge CLOCK_50);
    pk_en = 1'b0;
  endtask

  // Issues one request and records every write and dot pulse until done (or budget runs out).
  task automatic drive_move(input int cx, input int cy, input int nx, input int ny,
                            output int done_cyc, output logic blk);
    done_cyc = -1; blk = 1'bx;
    obs_wr.delete(); obs_dot.delete();
    repeat (2) @(negedge CLOCK_50);
    bus.curr_x = 6'(cx); bus.curr_y = 5'(cy);
    bus.next_x = 6'(nx); bus.next_y = 5'(ny);
    bus.req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLOCK_50); #1;
      if (bus.ram_wren) obs_wr.push_back('{bus.ram_addr, bus.ram_wdata, 8'(k + 1)});
      if (bus.dot_eaten) obs_dot.push_back(k + 1);
      if (bus.done) begin
        done_cyc = k + 1; blk = bus.blocked; bus.req = 1'b0;
        break;
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.curr_x = '0; bus.curr_y = '0; bus.next_x = '0; bus.next_y = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({bus.done, bus.blocked, bus.dot_eaten, bus.ram_wren} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got done/blk/dot/wren=%b exp=0000",
               {bus.done, bus.blocked, bus.dot_eaten, bus.ram_wren});
    end
    checks++;
    if (bus.ram_addr !== 11'd0 || bus.ram_wdata !== EMPTY) begin
      failures++;
      $display("FAIL reset_ram got addr=%0d wdata=%0d exp addr=0 wdata=0", bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if (bus.score !== SW'(0)) begin
      failures++; $display("FAIL reset_score got=%0d exp=0", bus.score);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  task automatic test_empty_move();
    int dc; logic bk; wr_t e, o;
    poke(ea(20, 20), PACMAN); poke(ea(20, 19), EMPTY);
    exp_wr.push_back('{11'(ea(20, 20)), EMPTY, 8'd3});
    exp_wr.push_back('{11'(ea(20, 19)), PACMAN, 8'd4});
    drive_move(20, 20, 20, 19, dc, bk);
    checks++;
    if (dc !== 5 || bk !== 1'b0) begin
      failures++; $display("FAIL empty_done got cyc=%0d blk=%b exp cyc=5 blk=0", dc, bk);
    end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); checks++;
      o = (obs_wr.size() != 0) ? obs_wr.pop_front() : '1;
      if (o !== e) begin
        failures++;
        $display("FAIL empty_wr got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                 o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || obs_dot.size() != 0) begin
      failures++; $display("FAIL empty_extra got wr=%0d dot=%0d exp 0/0", obs_wr.size(), obs_dot.size());
    end
    checks++;
    if (bus.score !== SW'(exp_score)) begin
      failures++; $display("FAIL empty_score got=%0d exp=%0d", bus.score, exp_score);
    end
    @(posedge CLOCK_50); #1;
    checks++;
    if (bus.done !== 1'b0 || mem[ea(20, 19)] !== PACMAN) begin
      failures++; $display("FAIL empty_after got done=%b tile=%0d exp done=0 tile=3", bus.done, mem[ea(20, 19)]);
    end
  endtask

  task automatic test_dot_move();
    int dc; logic bk; wr_t e, o;
    poke(ea(21, 20), DOT);
    exp_wr.push_back('{11'(ea(20, 20)), EMPTY, 8'd3});
    exp_wr.push_back('{11'(ea(21, 20)), PACMAN, 8'd4});
    exp_score = next_score(exp_score);
    drive_move(20, 20, 21, 20, dc, bk);
    checks++;
    if (dc !== 5 || bk !== 1'b0) begin
      failures++; $display("FAIL dot_done got cyc=%0d blk=%b exp cyc=5 blk=0", dc, bk);
    end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); checks++;
      o = (obs_wr.size() != 0) ? obs_wr.pop_front() : '1;
      if (o !== e) begin
        failures++;
        $display("FAIL dot_wr got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                 o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++;
    if (obs_dot.size() != 1 || obs_dot[0] != 4) begin
      failures++; $display("FAIL dot_pulse got count=%0d exp one pulse in cycle 4", obs_dot.size());
    end
    checks++;
    if (bus.score !== SW'(exp_score)) begin
      failures++; $display("FAIL dot_score got=%0d exp=%0d", bus.score, exp_score);
    end
  endtask

  task automatic test_wall();
    int dc; logic bk;
    poke(ea(19, 20), WALL);
    drive_move(20, 20, 19, 20, dc, bk);
    checks++;
    if (dc !== 3 || bk !== 1'b1) begin
      failures++; $display("FAIL wall_done got cyc=%0d blk=%b exp cyc=3 blk=1", dc, bk);
    end
    checks++;
    if (obs_wr.size() != 0 || obs_dot.size() != 0 || mem[ea(19, 20)] !== WALL) begin
      failures++;
      $display("FAIL wall_nowrite got wr=%0d dot=%0d tile=%0d exp 0/0/1", obs_wr.size(), obs_dot.size(), mem[ea(19, 20)]);
    end
  endtask

  task automatic test_offmap();
    int tbl [4][4] = '{'{0, 5, 63, 5}, '{39, 29, 40, 29}, '{5, 29, 5, 30}, '{5, 0, 5, 31}};
    int dc; logic bk;
    for (int i = 0; i < 4; i++) begin
      drive_move(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], dc, bk);
      checks++;
      if (dc !== 1 || bk !== 1'b1 || obs_wr.size() != 0) begin
        failures++;
        $display("FAIL offmap_%0d got cyc=%0d blk=%b wr=%0d exp cyc=1 blk=1 wr=0", i, dc, bk, obs_wr.size());
      end
    end
  endtask

  task automatic test_noop();
    int dc; logic bk;
    drive_move(10, 10, 10, 10, dc, bk);
    checks++;
    if (dc !== 1 || bk !== 1'b0 || obs_wr.size() != 0) begin
      failures++; $display("FAIL noop got cyc=%0d blk=%b wr=%0d exp cyc=1 blk=0 wr=0", dc, bk, obs_wr.size());
    end
  endtask

  task automatic test_corner();
    int dc; logic bk; wr_t e, o;
    poke(ea(39, 29), EMPTY);
    exp_wr.push_back('{11'(ea(38, 29)), EMPTY, 8'd3});
    exp_wr.push_back('{11'd1199, PACMAN, 8'd4});
    drive_move(38, 29, 39, 29, dc, bk);
    checks++;
    if (dc !== 5 || bk !== 1'b0) begin
      failures++; $display("FAIL corner_done got cyc=%0d blk=%b exp cyc=5 blk=0", dc, bk);
    end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); checks++;
      o = (obs_wr.size() != 0) ? obs_wr.pop_front() : '1;
      if (o !== e) begin
        failures++;
        $display("FAIL corner_wr got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                 o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_score_sat();
    int dc; logic bk;
    for (int i = 0; i < 4; i++) begin
      poke(ea(2, 1), DOT);
      exp_score = next_score(exp_score);
      drive_move(1, 1, 2, 1, dc, bk);
      checks++;
      if (dc !== 5 || bk !== 1'b0 || obs_dot.size() != 1 || bus.score !== SW'(exp_score)) begin
        failures++;
        $display("FAIL score_sat_%0d got cyc=%0d blk=%b dots=%0d score=%0d exp cyc=5 blk=0 dots=1 score=%0d",
                 i, dc, bk, obs_dot.size(), bus.score, exp_score);
      end
    end
  endtask

  task automatic test_reset_mid_erase();
    logic seen; int nd, nw;
    poke(ea(6, 5), EMPTY); poke(ea(5, 5), PACMAN);
    repeat (2) @(negedge CLOCK_50);
    bus.curr_x = 6'd5; bus.curr_y = 5'd5; bus.next_x = 6'd6; bus.next_y = 5'd5;
    bus.req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLOCK_50); #1;
      if (bus.ram_wren) begin seen = 1'b1; break; end
    end
    bus.req = 1'b0;
    checks++;
    if (!seen || bus.ram_addr !== 11'(ea(5, 5))) begin
      failures++; $display("FAIL midrst_erase got seen=%b addr=%0d exp seen=1 addr=%0d", seen, bus.ram_addr, ea(5, 5));
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_wren !== 1'b0) begin
      failures++; $display("FAIL midrst_wren got=%b exp=0 before next edge", bus.ram_wren);
    end
    exp_score = 0;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    nd = 0; nw = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLOCK_50); #1;
      if (bus.done) nd++;
      if (bus.ram_wren) nw++;
    end
    checks++;
    if (nd != 0 || nw != 0 || mem[ea(6, 5)] !== EMPTY || bus.score !== SW'(exp_score)) begin
      failures++;
      $display("FAIL midrst_after got done=%0d wren=%0d tile=%0d score=%0d exp 0/0/0/0", nd, nw, mem[ea(6, 5)], bus.score);
    end
  endtask

  initial begin
    test_reset();
    test_empty_move();
    test_dot_move();
    test_wall();
    test_offmap();
    test_noop();
    test_corner();
    test_score_sat();
    test_reset_mid_erase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pacman_map_writer.md
# pacman_map_writer

Responder side of the pacman move handshake. Accepts a move request carrying pacman's current and next tile coordinates, reads the target tile from the game-map RAM, and either rejects the move (wall or off-map) or erases pacman from the current tile and draws him on the next tile. Completion is signalled with a one-cycle `done` pulse. Sits between the pacman location controller and the single-port tile-map RAM that the VGA renderer also reads.

## Interface
Parameters:
- `MAP_W`, 40: map width in tiles; valid x is 0..MAP_W-1.
- `MAP_H`, 30: map height in tiles; valid y is 0..MAP_H-1.
- `SCORE_W`, 16: score counter width.

Ports:
- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  move request, level; sampled only in IDLE.
- `curr_x` / `next_x`  in  6  current and next tile x.
- `curr_y` / `next_y`  in  5  current and next tile y.
- `done`  out  1  one-cycle pulse; the request is finished.
- `blocked`  out  1  valid with `done`; 1 = move rejected, map unchanged.
- `dot_eaten`  out  1  one-cycle pulse when pacman is placed on a DOT tile.
- `score`  out  SCORE_W  count of dots eaten.
- `ram_addr`  out  11  tile address = y*MAP_W + x.
- `ram_wren`  out  1  RAM write enable.
- `ram_wdata`  out  2  tile code to write.
- `ram_rdata`  in  2  RAM read data; one-cycle synchronous read latency.

## Operation
- Tile codes (2 bits): EMPTY=0, WALL=1, DOT=2, PACMAN=3.
- States: IDLE, LOOKUP, EVAL, ERASE, PLACE, FINISH.
- IDLE:
  - On `req`=1, latch all four coordinates.
  - If next is off-map (x≥MAP_W or y≥MAP_H, which includes 0−1 wrap to 63/31), go to FINISH with blocked=1.
  - Else if next equals curr, go to FINISH with blocked=0 and perform no writes.
  - Else go to LOOKUP.
- LOOKUP: drive `ram_addr` = addr(next) with `ram_wren`=0.
- EVAL:
  - `ram_rdata` is valid in this state.
  - WALL → FINISH with blocked=1.
  - Otherwise latch the DOT flag and go to ERASE.
- ERASE: `ram_wren`=1, `ram_addr` = addr(curr), `ram_wdata` = EMPTY.
- PLACE:
  - `ram_wren`=1, `ram_addr` = addr(next), `ram_wdata` = PACMAN.
  - If the DOT flag is set, pulse `dot_eaten` and increment `score`.
- FINISH: `done`=1 with the registered `blocked` value, then return to IDLE.
- Address arithmetic: y*40 + x, computed as (y<<5)+(y<<3)+x in 11 bits; maximum 1199.
- `req` and coordinate changes outside IDLE are ignored. Coordinates are used only as latched.
- `req` still high in the cycle after FINISH starts a new transaction. The requester must drop `req` on `done`.
- `blocked`=1 with `done` means pacman did not move. The requester must keep its current coordinates.
- `score` saturates at all-ones; it never wraps.

## Timing
- Reset values: state=IDLE, `done`=0, `blocked`=0, `dot_eaten`=0, `score`=0, `ram_wren`=0, `ram_addr`=0, `ram_wdata`=EMPTY.
- Reset is asynchronous. Asserting it mid-transaction drops `ram_wren` immediately and discards the move.
- Latency is counted from the IDLE cycle that samples `req` (cycle 0):
  - Full move: LOOKUP at 1, EVAL at 2, ERASE at 3, PLACE at 4, `done` at 5.
  - Wall: `done` at 3.
  - Off-map or no-op: `done` at 1.
- `ram_addr`, `ram_wren` and `ram_wdata` are registered-equivalent: glitch-free and constant for the whole state.
- `ram_wren` is high for exactly two cycles per successful move and 0 otherwise.

## Configuration
- `PACMAN_SCORE_EN`
  - Defined: the score counter is present and behaves as above.
  - Undefined: the counter is removed and `score` is tied to 0.
  - In both cases `dot_eaten` still pulses.

## Structure
- `pacman_pkg` holds:
  - the tile-code typedef (EMPTY/WALL/DOT/PACMAN);
  - the `MAP_W`/`MAP_H` defaults;
  - the `tile_addr(x, y)` function, shared with the renderer and the location controller.
- The FSM state enum is local to this module.
- One sub-module, `tile_addr_calc`: a combinational coordinate-to-address and in-range check, instantiated twice (curr, next).

## Test plan
- Reset, then req with curr=(20,20), next=(20,19), RAM(20,19)=EMPTY:
  - writes EMPTY@820 in cycle 3 and PACMAN@780 in cycle 4;
  - `done` in cycle 5 with blocked=0; `score` stays 0.
- next=(21,20) holding DOT: writes EMPTY@820, PACMAN@821; `dot_eaten` pulses with PLACE; `score`=1.
- next=(19,20) holding WALL: no `ram_wren`; `done` in cycle 3 with blocked=1.
- curr=(0,5), next=(63,5) (left wrap): no RAM access; `done` in cycle 1 with blocked=1.
- `reset_n` low during ERASE: `ram_wren` falls without waiting for a clock edge; no PLACE write occurs; `done` is never asserted.
- `score` preloaded near all-ones via repeated DOT moves with `SCORE_W`=2: `score` holds at 3 after the fourth dot.
